// File: rtl/bus_fabric_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_fabric_if                                                |
// | Description : CPU memory port plus fanned-out slave request/response       |
// |               signals of bus_fabric.                                       |
// |               Modport "slave" is the fabric's view: it answers CPU         |
// |               requests and drives the slave selects.                       |
// |               Modport "master" is the surrounding system's view: the CPU   |
// |               and the slave blocks.                                        |
// |   mem_valid/mem_addr            CPU request                                |
// |   mem_ready/mem_rdata/mem_error completion pulse, data, error flag         |
// |   slave_valid                   one-hot slave request                      |
// |   slave_ready/slave_rdata       per-slave ready, flattened read data       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bus_fabric_if #(
    parameter int N_SLAVES = 8
);
    logic                     mem_valid;
    logic [31:0]              mem_addr;
    logic                     mem_ready;
    logic [31:0]              mem_rdata;
    logic                     mem_error;
    logic [N_SLAVES-1:0]      slave_valid;
    logic [N_SLAVES-1:0]      slave_ready;
    logic [32*N_SLAVES-1:0]   slave_rdata;

    modport slave (
        input  mem_valid, mem_addr, slave_ready, slave_rdata,
        output mem_ready, mem_rdata, mem_error, slave_valid
    );

    modport master (
        output mem_valid, mem_addr, slave_ready, slave_rdata,
        input  mem_ready, mem_rdata, mem_error, slave_valid
    );
endinterface
`default_nettype wire

// File: rtl/bus_fabric.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_fabric                                                   |
// | Description : Registered address decoder / response router between the    |
// |               CPU memory port and up to 16 slaves. A request is latched,  |
// |               one slave is selected one-hot, and unmapped slots or hung   |
// |               slaves complete with an error response.                     |
// |   clk     : system clock                                                  |
// |   resetn  : asynchronous active-low reset                                 |
// |   bus     : bus_fabric_if.slave (CPU port + slave request/response)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bus_fabric #(
    parameter int          N_SLAVES  = 8,
    parameter logic [31:0] WIN_BASE  = 32'hFFFF0000,
    parameter int          SLOT_BITS = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         resetn,
    bus_fabric_if.slave  bus
);

    localparam int c_SEL_W   = $clog2(N_SLAVES);
    localparam int c_CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int c_TAG_LSB = SLOT_BITS + 4;

    localparam logic [c_CNT_W:0]     c_TIMEOUT     = (c_CNT_W + 1)'(TIMEOUT);
    localparam logic [c_CNT_W:0]     c_CNT_ONE     = (c_CNT_W + 1)'(1);
    localparam logic [4:0]           c_LAST_SLOT   = 5'(N_SLAVES - 1);
    localparam logic [c_SEL_W-1:0]   c_DEFAULT_SEL = c_SEL_W'(N_SLAVES - 1);
    localparam logic [N_SLAVES-1:0]  c_SV_ONE      = N_SLAVES'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]          r_state, w_state_nxt;
    logic [c_SEL_W-1:0]  r_sel, w_sel_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]         r_mem_rdata, w_mem_rdata_nxt;
    logic                r_mem_error, w_mem_error_nxt;
    logic                r_mem_ready, w_mem_ready_nxt;
    logic [N_SLAVES-1:0] r_slave_valid, w_slave_valid_nxt;

    // ---------------- address decode (meaningful in IDLE only) --------------
    logic               w_in_window;
    logic [3:0]         w_slot;
    logic               w_unmapped;
    logic [c_SEL_W-1:0] w_dec_sel;
    logic               w_unused_addr;

    assign w_in_window = (bus.mem_addr[31:c_TAG_LSB] == WIN_BASE[31:c_TAG_LSB]);
    assign w_slot      = bus.mem_addr[SLOT_BITS+3:SLOT_BITS];
    // Slots at or above the default slave's index have no peripheral behind them.
    assign w_unmapped  = w_in_window && ({1'b0, w_slot} >= c_LAST_SLOT);
    assign w_dec_sel   = w_in_window ? w_slot[c_SEL_W-1:0] : c_DEFAULT_SEL;
    // Byte offset within a slot does not take part in the decode.
    assign w_unused_addr = &{1'b0, bus.mem_addr[SLOT_BITS-1:0]};

    // ---------------- selected-slave response -------------------------------
    logic              w_sel_ready;
    logic [31:0]       w_sel_rdata;
    logic [c_CNT_W:0]  w_cnt_inc;
    logic              w_timeout;

    assign w_sel_ready = bus.slave_ready[r_sel];
    assign w_sel_rdata = bus.slave_rdata[{r_sel, 5'd0} +: 32];
    assign w_cnt_inc   = {1'b0, r_cnt} + c_CNT_ONE;
    // This ACTIVE cycle is number r_cnt+1; the one that reaches TIMEOUT is the last.
    assign w_timeout   = (TIMEOUT != 0) && (w_cnt_inc == c_TIMEOUT);

    // ---------------- state register ----------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic --------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    w_state_nxt = w_unmapped ? S_RESP : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // mem_valid is deliberately not looked at: a started transaction always completes.
                if (w_sel_ready || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic (next values of the registered outputs) --
    always_comb begin
        w_sel_nxt       = r_sel;
        w_cnt_nxt       = r_cnt;
        w_mem_rdata_nxt = r_mem_rdata;
        w_mem_error_nxt = r_mem_error;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    if (w_unmapped) begin
                        w_mem_rdata_nxt = 32'd0;
                        w_mem_error_nxt = 1'b1;
                    end else begin
                        w_sel_nxt = w_dec_sel;
                        w_cnt_nxt = '0;
                    end
                end
            end
            S_ACTIVE: begin
                // Ready on the timeout boundary still counts as a normal completion.
                if (w_sel_ready) begin
                    w_mem_rdata_nxt = w_sel_rdata;
                    w_mem_error_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_mem_rdata_nxt = 32'd0;
                    w_mem_error_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc[c_CNT_W-1:0];
                end
            end
            default: ;
        endcase
        w_mem_ready_nxt   = (w_state_nxt == S_RESP);
        w_slave_valid_nxt = (w_state_nxt == S_ACTIVE) ? (c_SV_ONE << w_sel_nxt) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel         <= '0;
            r_cnt         <= '0;
            r_mem_rdata   <= 32'd0;
            r_mem_error   <= 1'b0;
            r_mem_ready   <= 1'b0;
            r_slave_valid <= '0;
        end else begin
            r_sel         <= w_sel_nxt;
            r_cnt         <= w_cnt_nxt;
            r_mem_rdata   <= w_mem_rdata_nxt;
            r_mem_error   <= w_mem_error_nxt;
            r_mem_ready   <= w_mem_ready_nxt;
            r_slave_valid <= w_slave_valid_nxt;
        end
    end

    assign bus.mem_ready   = r_mem_ready;
    assign bus.mem_rdata   = r_mem_rdata;
    assign bus.mem_error   = r_mem_error;
    assign bus.slave_valid = r_slave_valid;

endmodule
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bus_fabric                                                |
// | Description : Directed self-checking bench for bus_fabric (N_SLAVES=8,     |
// |               TIMEOUT=4). A transaction-level model predicts per-cycle     |
// |               outputs; literal expectations pin the main scenarios.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bus_fabric;

    localparam int          N     = 8;
    localparam int          TMO   = 4;
    localparam int          SB    = 4;
    localparam logic [31:0] WB    = 32'hFFFF0000;
    localparam int          DEPTH = 1024;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    bus_fabric_if #(.N_SLAVES(N)) bus ();

    bus_fabric #(
        .N_SLAVES  (N),
        .WIN_BASE  (WB),
        .SLOT_BITS (SB),
        .TIMEOUT   (TMO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave behaviour ---------------------------------------
    logic [N-1:0] ready_tie;
    int           ready_slave;
    int           ready_cyc;
    logic [31:0]  srd [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            bus.slave_ready[k]        = ready_tie[k] | ((ready_slave == k) && (cyc == ready_cyc));
            bus.slave_rdata[32*k +: 32] = srd[k];
        end
    end

    // ---------------- checking ----------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    bit run_chk  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model: expected outputs indexed by cycle --------------
    logic [N-1:0] exp_sv  [DEPTH];
    bit           exp_rdy [DEPTH];
    bit           exp_err [DEPTH];
    logic [31:0]  exp_rd  [DEPTH];

    task automatic clear_from(input int c);
        for (int i = c; i < DEPTH; i++) begin
            exp_sv[i] = '0; exp_rdy[i] = 1'b0; exp_err[i] = 1'b0; exp_rd[i] = 32'd0;
        end
    endtask

    // Request sampled at cycle c0: decode, find first ready cycle, fill the timeline.
    task automatic sched(input int c0, input logic [31:0] a);
        int sel, slot, j;
        bit found;
        slot = int'((a >> SB) & 32'hF);
        if ((a >> (SB + 4)) == (WB >> (SB + 4))) begin
            if (slot >= N - 1) begin
                exp_rdy[c0+1] = 1'b1; exp_err[c0+1] = 1'b1; exp_rd[c0+1] = 32'd0;
                return;
            end
            sel = slot;
        end else begin
            sel = N - 1;
        end
        found = 1'b0;
        j = 0;
        for (int i = 1; i <= TMO && !found; i++) begin
            j = i;
            found = ready_tie[sel] || ((ready_slave == sel) && (ready_cyc == c0 + i));
        end
        for (int i = 1; i <= j; i++) exp_sv[c0+i] = N'(1) << sel;
        exp_rdy[c0+j+1] = 1'b1;
        exp_err[c0+j+1] = !found;
        exp_rd[c0+j+1]  = found ? srd[sel] : 32'd0;
    endtask

    logic [31:0] held_rd  = 32'd0;
    logic        held_err = 1'b0;

    always @(negedge clk) begin
        if (run_chk && cyc < DEPTH) begin
            if (!resetn) begin
                held_rd  = 32'd0;
                held_err = 1'b0;
            end else if (exp_rdy[cyc]) begin
                held_rd  = exp_rd[cyc];
                held_err = exp_err[cyc];
            end
            chk("slave_valid", 32'(bus.slave_valid), 32'(exp_sv[cyc]));
            chk("mem_ready",   32'(bus.mem_ready),   32'(exp_rdy[cyc]));
            chk("mem_rdata",   bus.mem_rdata,        held_rd);
            chk("mem_error",   32'(bus.mem_error),   32'(held_err));
            chk("onehot0",     32'($onehot0(bus.slave_valid)), 32'd1);
        end
    end

    // ---------------- transaction driver ------------------------------------
    // rdly < 0: no delayed ready; else slave rs is ready for one cycle at c0+1+rdly.
    // Returns one cycle after mem_ready with mem_valid still high.
    task automatic txn(input logic [31:0] a, input int rs, input int rdly,
                       output int c0, output int lat, output logic [N-1:0] sv_or,
                       output int sv_n, output logic [31:0] rd, output logic err);
        bit done;
        done = 1'b0;
        c0 = cyc;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        ready_slave   = rs;
        ready_cyc     = (rdly < 0) ? -1 : cyc + 1 + rdly;
        sched(c0, a);
        lat = -1; sv_or = '0; sv_n = 0; rd = 32'd0; err = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk); #1;
            if (bus.slave_valid != '0) begin
                sv_n++;
                sv_or |= bus.slave_valid;
            end
            if (bus.mem_ready) begin
                done = 1'b1;
                lat  = cyc - c0;
                rd   = bus.mem_rdata;
                err  = bus.mem_error;
            end
        end
        chk("txn_completes", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.mem_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- directed stimulus -------------------------------------
    int c0, c0b, lat, svn;
    logic [N-1:0] svo;
    logic [31:0]  rd;
    logic         err;

    initial begin
        clear_from(0);
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'd0;
        ready_tie     = '0;
        ready_slave   = -1;
        ready_cyc     = -1;
        for (int k = 0; k < N; k++) srd[k] = 32'hA000_0000 + 32'(k);
        srd[7] = 32'hCAFEF00D;
        srd[5] = 32'h12345678;
        srd[2] = 32'hDEADBEEF;
        srd[3] = 32'h33333333;

        #2 resetn = 1'b0;
        run_chk = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_slave_valid", 32'(bus.slave_valid), 32'd0);
        idle(2);

        // default slave, combinational ready
        ready_tie = 8'h80;
        txn(32'h00001000, -1, -1, c0, lat, svo, svn, rd, err);
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_sv", 32'(svo), 32'h80);
        chk("t1_rdata", rd, 32'hCAFEF00D);
        chk("t1_error", 32'(err), 32'd0);
        idle(2);

        // slave 5 ready at cycle 4, slave 2 ready noise ignored
        ready_tie = 8'h04;
        txn(32'hFFFF0050, 5, 3, c0, lat, svo, svn, rd, err);
        chk("t2_latency", 32'(lat), 32'd5);
        chk("t2_sv", 32'(svo), 32'h20);
        chk("t2_sv_cycles", 32'(svn), 32'd4);
        chk("t2_rdata", rd, 32'h12345678);
        idle(2);

        // unmapped slot 7
        ready_tie = 8'hFF;
        txn(32'hFFFF0070, -1, -1, c0, lat, svo, svn, rd, err);
        chk("t3_latency", 32'(lat), 32'd1);
        chk("t3_sv", 32'(svo), 32'h00);
        chk("t3_error", 32'(err), 32'd1);
        chk("t3_rdata", rd, 32'd0);
        idle(2);

        // timeout: slave 3 never ready
        ready_tie = 8'h00;
        txn(32'hFFFF0030, -1, -1, c0, lat, svo, svn, rd, err);
        chk("t4a_latency", 32'(lat), 32'd5);
        chk("t4a_sv_cycles", 32'(svn), 32'd4);
        chk("t4a_sv", 32'(svo), 32'h08);
        chk("t4a_error", 32'(err), 32'd1);
        idle(2);

        // ready on the timeout boundary wins
        txn(32'hFFFF0030, 3, 3, c0, lat, svo, svn, rd, err);
        chk("t4b_latency", 32'(lat), 32'd5);
        chk("t4b_error", 32'(err), 32'd0);
        chk("t4b_rdata", rd, 32'h33333333);
        idle(2);

        // back-to-back: slave 1 then slave 4
        ready_tie = 8'h12;
        txn(32'hFFFF0010, -1, -1, c0, lat, svo, svn, rd, err);
        chk("t5a_latency", 32'(lat), 32'd2);
        txn(32'hFFFF0040, -1, -1, c0b, lat, svo, svn, rd, err);
        chk("t5b_start", 32'(c0b - c0), 32'd3);
        chk("t5b_latency", 32'(lat), 32'd2);
        chk("t5b_sv", 32'(svo), 32'h10);
        idle(2);

        // reset in the middle of a stalled request
        ready_tie = 8'h00;
        ready_slave = -1;
        ready_cyc   = -1;
        c0 = cyc;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'hFFFF0030;
        sched(c0, 32'hFFFF0030);
        repeat (2) begin @(posedge clk); #1; end
        chk("t6_sv_before", 32'(bus.slave_valid), 32'h08);
        resetn = 1'b0;
        bus.mem_valid = 1'b0;
        clear_from(cyc);
        #1;
        chk("t6_sv_reset", 32'(bus.slave_valid), 32'd0);
        chk("t6_ready_reset", 32'(bus.mem_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        idle(1);
        ready_tie = 8'h80;
        txn(32'h00002000, -1, -1, c0, lat, svo, svn, rd, err);
        chk("t6_latency", 32'(lat), 32'd2);
        chk("t6_rdata", rd, 32'hCAFEF00D);
        idle(3);

        run_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_fabric.md
# bus_fabric

Registered, parametrised address decoder and response router between the CPU memory port and up to 16 slaves. It replaces the combinational peripheral decode with a three-state handshake engine. Each request is latched, and exactly one slave is selected with a one-hot `slave_valid`. Unmapped peripheral slots and hung slaves complete with an error response instead of stalling the core. It sits directly between the CPU `mem_*` port and the memory, UART, timer, PRNG and GPIO blocks.

## Interface
Parameters:
- `N_SLAVES`, 8: number of slaves, legal range 2..16. Slave `N_SLAVES-1` is the default (memory) slave.
- `WIN_BASE`, 32'hFFFF0000: base of the peripheral window. Only bits [31:SLOT_BITS+4] are compared.
- `SLOT_BITS`, 4: log2 of slot size in bytes. The window holds 16 slots.
- `TIMEOUT`, 255: maximum cycles `slave_valid` stays high before an error completion. A value of 0 disables the timeout.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  CPU request, held until `mem_ready`.
- `mem_addr`  in  32  request address.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  registered read data, valid while `mem_ready` is high.
- `mem_error`  out  1  qualifies `mem_ready`: the request was unmapped or timed out.
- `slave_valid`  out  N_SLAVES  one-hot registered slave select/request.
- `slave_ready`  in  N_SLAVES  per-slave ready.
- `slave_rdata`  in  32*N_SLAVES  flattened read data. Slave k occupies bits [32k+31:32k].

## Operation
Decode, evaluated on `mem_addr` in IDLE:
- In-window: `mem_addr[31:SLOT_BITS+4] == WIN_BASE[31:SLOT_BITS+4]`.
- Slot index: `s = mem_addr[SLOT_BITS+3:SLOT_BITS]`.
- In-window with s < N_SLAVES-1: selects slave s.
- In-window with s >= N_SLAVES-1: unmapped.
- Out-of-window: selects slave N_SLAVES-1.

State machine, reset state IDLE:
- IDLE with `mem_valid` and a mapped address:
  - Register `sel`.
  - Set `slave_valid[sel]`.
  - Clear the timeout counter.
  - Next state ACTIVE.
- IDLE with `mem_valid` and an unmapped address:
  - Load `mem_rdata=0`, `mem_error=1`.
  - Next state RESP. No `slave_valid` is raised.
- ACTIVE: only `slave_ready[sel]` is observed; all other ready bits are ignored.
  - `slave_ready[sel]` high: capture `slave_rdata[sel]` into `mem_rdata`, clear `slave_valid`, `mem_error=0`, next state RESP.
  - Otherwise the counter increments.
  - Counter reaches TIMEOUT (TIMEOUT≠0) with ready still low: clear `slave_valid`, `mem_rdata=0`, `mem_error=1`, next state RESP.
  - Ready in the same cycle as the timeout boundary wins, so the completion is normal.
- RESP: `mem_ready=1` for exactly this cycle, then IDLE.
  - `mem_rdata` and `mem_error` hold their values until the next RESP.

Other rules:
- `mem_valid` dropping in ACTIVE is a protocol violation. The transaction completes normally and `mem_ready` still pulses.
- `slave_valid` is always one-hot or zero, and is never high outside ACTIVE.

## Timing
- Reset (async assert, sync deassert externally): state=IDLE, `slave_valid=0`, `mem_ready=0`, `mem_rdata=0`, `mem_error=0`, counter=0. Reset mid-transaction aborts immediately and no `mem_ready` is produced.
- Cycle numbering uses cycle 0 for the first `mem_valid` sampled in IDLE.
- Mapped request:
  - `slave_valid` is high from cycle 1.
  - If ready arrives at cycle 1+k, `mem_ready` pulses at cycle 2+k.
  - Minimum latency is 2 cycles (combinational slave ready).
- Unmapped request: `mem_ready`+`mem_error` at cycle 1.
- Timeout: `slave_valid` is high for exactly TIMEOUT cycles (1..TIMEOUT), and `mem_ready`+`mem_error` pulse at cycle TIMEOUT+1.
- Back-to-back: a new `mem_valid` sampled in the cycle after RESP starts the next transaction. RESP never accepts a request.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Read at 32'h00001000, slave 7 ready tied high with rdata 32'hCAFEF00D: `slave_valid=8'h80` at cycle 1; `mem_ready=1`, `mem_rdata=32'hCAFEF00D`, `mem_error=0` at cycle 2.
- Read at 32'hFFFF0050, slave 5 ready delayed 3 cycles with rdata 32'h12345678: `slave_valid=8'h20` for cycles 1–4; `mem_ready` at cycle 5 with 32'h12345678. Slave 2 ready held high throughout has no effect.
- Read at 32'hFFFF0070 (slot 7, N_SLAVES=8, unmapped): `slave_valid` stays 0; `mem_ready=1`, `mem_error=1`, `mem_rdata=0` at cycle 1.
- TIMEOUT=4, read at 32'hFFFF0030, slave 3 never ready: `slave_valid[3]` high for cycles 1–4; error response at cycle 5. Repeat with ready at cycle 4: normal completion at cycle 5.
- Two back-to-back requests, to slave 1 then slave 4, both ready-high: `mem_ready` at cycles 2 and 5. `slave_valid` is never multi-hot.
- `resetn` pulsed low at cycle 2 of a stalled request: `slave_valid=0` and state IDLE immediately; no `mem_ready`. The next request after release completes normally.
